// File: rtl/fir_out_buffer_pkg.sv
// Shared definitions for the FIR output path: core sample width and a
// constant-evaluable ceiling log2 used to size pointers and counters.
package fir_out_buffer_pkg;

  localparam int FIR_DATA_W = 16;

  function automatic int clog2(input int value);
    int r;
    r = 32'sd0;
    while ((32'sd1 <<< r) < value) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_out_buffer_sync_fifo.sv
// First-word-fall-through synchronous FIFO. The caller only pushes when not
// full (or popping in the same cycle) and only pops when not empty.
module fir_out_buffer_sync_fifo
  import fir_out_buffer_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  pop,
  output logic [DATA_W-1:0]     rdata,
  output logic [clog2(DEPTH):0] count,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;

  // Sample storage; left unreset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy; a full-with-pop write lands in the slot being read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_r + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/fir_out_buffer.sv
// Captures every FIR output beat (the core cannot be stalled), optionally
// decimates, buffers, and re-presents samples on a back-pressured AXI-Stream master.
module fir_out_buffer
  import fir_out_buffer_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int DEPTH  = 16,
  parameter int DECIM  = 1
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  s_axis_data_tvalid,
  input  logic [DATA_W-1:0]     s_axis_data_tdata,
  output logic                  m_axis_data_tvalid,
  input  logic                  m_axis_data_tready,
  output logic [DATA_W-1:0]     m_axis_data_tdata,
  output logic [clog2(DEPTH):0] fill_level,
  output logic                  overflow,
  input  logic                  clear_ovf
);

  localparam int DW = (DECIM > 1) ? clog2(DECIM) : 1;
  localparam logic [DW-1:0] DCNT_LAST = DW'(DECIM - 1);

  logic [DW-1:0]     dcnt_r;
  logic              overflow_r;
  logic              kept_s;
  logic              push_s;
  logic              pop_s;
  logic              drop_s;
  logic              full_s;
  logic              empty_s;
  logic [DATA_W-1:0] rdata_s;

  // Push qualification: a kept beat may use a slot freed by a same-cycle pop.
  always_comb begin
    kept_s = 1'b0;
    pop_s  = 1'b0;
    push_s = 1'b0;
    drop_s = 1'b0;
    kept_s = s_axis_data_tvalid && (dcnt_r == {DW{1'b0}});
    pop_s  = !empty_s && m_axis_data_tready;
    push_s = kept_s && (!full_s || pop_s);
    drop_s = kept_s && full_s && !pop_s;
  end

  // Decimation phase, advanced by every input beat whether kept or not.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      dcnt_r <= {DW{1'b0}};
    end else if (s_axis_data_tvalid) begin
      if (dcnt_r == DCNT_LAST) begin
        dcnt_r <= {DW{1'b0}};
      end else begin
        dcnt_r <= dcnt_r + DW'(1);
      end
    end
  end

  // Sticky overflow; a drop in the same cycle wins over a clear request.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (clear_ovf) begin
      overflow_r <= 1'b0;
    end
  end

  fir_out_buffer_sync_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk  (aclk),
    .rst  (areset),
    .push (push_s),
    .wdata(s_axis_data_tdata),
    .pop  (pop_s),
    .rdata(rdata_s),
    .count(fill_level),
    .full (full_s),
    .empty(empty_s)
  );

  // Output stage: valid is the registered occupancy compare; data is zeroed when idle.
  always_comb begin
    m_axis_data_tvalid = !empty_s;
    if (!empty_s) begin
      m_axis_data_tdata = rdata_s;
    end else begin
      m_axis_data_tdata = {DATA_W{1'b0}};
    end
  end

  assign overflow = overflow_r;

endmodule

// File: tb/tb_fir_out_buffer.sv
// Scoreboard bench: a DECIM=1 and a DECIM=4 instance driven side by side,
// each tracked by a small behavioural model of count, overflow and sample order.
module tb_fir_out_buffer;

  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic          aclk;
  logic          areset;
  logic          in_valid [2];
  logic [DW-1:0] in_data  [2];
  logic          tready   [2];
  logic          clr      [2];
  logic          ovalid   [2];
  logic [DW-1:0] odata    [2];
  logic [4:0]    fill     [2];
  logic          ovf      [2];

  int n_assert = 0;
  int n_fail   = 0;

  int exp_cnt  [2];
  int exp_dcnt [2];
  bit exp_ovf  [2];
  logic [DW-1:0] sb0[$];
  logic [DW-1:0] sb1[$];

  fir_out_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .DECIM(1)) dut1 (
    .aclk(aclk), .areset(areset),
    .s_axis_data_tvalid(in_valid[0]), .s_axis_data_tdata(in_data[0]),
    .m_axis_data_tvalid(ovalid[0]), .m_axis_data_tready(tready[0]),
    .m_axis_data_tdata(odata[0]), .fill_level(fill[0]),
    .overflow(ovf[0]), .clear_ovf(clr[0])
  );

  fir_out_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .DECIM(4)) dut4 (
    .aclk(aclk), .areset(areset),
    .s_axis_data_tvalid(in_valid[1]), .s_axis_data_tdata(in_data[1]),
    .m_axis_data_tvalid(ovalid[1]), .m_axis_data_tready(tready[1]),
    .m_axis_data_tdata(odata[1]), .fill_level(fill[1]),
    .overflow(ovf[1]), .clear_ovf(clr[1])
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic int decim_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic logic [DW-1:0] sb_front(input int d);
    if (d == 0) return sb0[0];
    else return sb1[0];
  endfunction

  task automatic sb_push(input int d, input logic [DW-1:0] v);
    if (d == 0) sb0.push_back(v);
    else sb1.push_back(v);
  endtask

  task automatic sb_pop(input int d);
    if (d == 0) void'(sb0.pop_front());
    else void'(sb1.pop_front());
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      exp_cnt[d]  = 0;
      exp_dcnt[d] = 0;
      exp_ovf[d]  = 1'b0;
    end
    sb0.delete();
    sb1.delete();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare current outputs against the model, then advance the model and the clock.
  task automatic tick();
    bit pop, kept, push, drop;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("tvalid[d%0d]", d), {31'd0, ovalid[d]}, {31'd0, exp_cnt[d] != 0});
      chk($sformatf("fill[d%0d]", d), {27'd0, fill[d]}, exp_cnt[d]);
      chk($sformatf("ovf[d%0d]", d), {31'd0, ovf[d]}, {31'd0, exp_ovf[d]});
      chk($sformatf("tdata[d%0d]", d), {16'd0, odata[d]},
          (exp_cnt[d] != 0) ? {16'd0, sb_front(d)} : 32'd0);
      pop  = (exp_cnt[d] != 0) && tready[d];
      kept = in_valid[d] && (exp_dcnt[d] == 0);
      push = kept && ((exp_cnt[d] < DEPTH) || pop);
      drop = kept && !push;
      if (pop) sb_pop(d);
      if (push) sb_push(d, in_data[d]);
      exp_cnt[d] = exp_cnt[d] + int'(push) - int'(pop);
      if (in_valid[d]) exp_dcnt[d] = (exp_dcnt[d] + 1) % decim_of(d);
      if (drop) exp_ovf[d] = 1'b1;
      else if (clr[d]) exp_ovf[d] = 1'b0;
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] data);
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = v;
      in_data[d]  = data;
    end
  endtask

  task automatic set_ready(input logic r);
    tready[0] = r;
    tready[1] = r;
  endtask

  task automatic set_clr(input logic c);
    clr[0] = c;
    clr[1] = c;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 16'h0000);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    areset = 1'b1;
    drive(1'b0, 16'h0000);
    set_ready(1'b1);
    set_clr(1'b0);
    model_reset();
    repeat (2) @(posedge aclk);
    #1;
    chk("reset_tvalid", {31'd0, ovalid[0]}, 32'd0);
    chk("reset_tdata", {16'd0, odata[0]}, 32'd0);
    areset = 1'b0;
    tick();

    // Test 1: consecutive pass-through beats, immediate drain
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, DW'(i));
      tick();
      chk("t1_fill_le1", {31'd0, fill[0] <= 5'd1}, 32'd1);
    end
    idle(4);

    // Test 2: decimation by 4 on the second instance
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, DW'(16'h0010 + i));
      tick();
    end
    idle(4);
    chk("t2_kept_none_left", {27'd0, fill[1]}, 32'd0);

    // Test 3: fill to DEPTH with tready low, then one dropped beat
    set_ready(1'b0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, DW'(16'h0100 + i));
      tick();
    end
    chk("t3_full", {27'd0, fill[0]}, 32'd16);
    chk("t3_no_ovf", {31'd0, ovf[0]}, 32'd0);
    drive(1'b1, 16'h0110);
    tick();
    chk("t3_full_after_drop", {27'd0, fill[0]}, 32'd16);
    chk("t3_ovf_set", {31'd0, ovf[0]}, 32'd1);

    // Test 5: clear coinciding with a drop must lose; clean clear afterwards wins
    set_clr(1'b1);
    drive(1'b1, 16'h0111);
    tick();
    chk("t5_ovf_held", {31'd0, ovf[0]}, 32'd1);
    drive(1'b0, 16'h0000);
    tick();
    set_clr(1'b0);
    chk("t5_ovf_cleared", {31'd0, ovf[0]}, 32'd0);

    // Test 4: full with simultaneous pop and push
    set_ready(1'b1);
    drive(1'b1, 16'h0ABC);
    tick();
    chk("t4_fill_stays", {27'd0, fill[0]}, 32'd16);
    chk("t4_no_ovf", {31'd0, ovf[0]}, 32'd0);
    idle(20);
    chk("t4_drained", {27'd0, fill[0]}, 32'd0);

    // Test 6: async reset mid-stream discards content and decimation phase
    set_ready(1'b0);
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, DW'(16'h0200 + i));
      tick();
    end
    chk("t6_fill5", {27'd0, fill[1]}, 32'd5);
    drive(1'b0, 16'h0000);
    areset = 1'b1;
    #2;
    chk("t6_rst_tvalid", {31'd0, ovalid[1]}, 32'd0);
    chk("t6_rst_tdata", {16'd0, odata[1]}, 32'd0);
    chk("t6_rst_fill", {27'd0, fill[1]}, 32'd0);
    chk("t6_rst_ovf1", {31'd0, ovf[0]}, 32'd0);
    model_reset();
    @(posedge aclk);
    #1;
    areset = 1'b0;
    set_ready(1'b1);
    drive(1'b1, 16'h0300);
    tick();
    chk("t6_first_kept", {16'd0, odata[1]}, 32'h0300);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
